dmw_addr_translate: RTL and testbench
=====================================

// Module: dmw_addr_translate
// PURPOSE
//  Read-side consumer of the DMW0/DMW1 CSRs. It translates a 32-bit virtual address to a physical
//  address for the LSU/IFU through a 2-stage pipeline with valid/ready handshakes.
//  Three translation outcomes: direct (CRMD.DA), direct-mapped window hit, or miss (handed to the TLB path).
//  It sits between the address-generation stage and the cache tag stage.
// PARAMETERS
//  HIT_CNT_W  32  width of saturating DMW-hit performance counter
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous, active-high reset
//  flush       in   1   pipeline flush; kills both stages
//  dmw0        in   32  DMW0 CSR value ([31:29] VSEG, [27:25] PSEG, [5:4] MAT, [3] PLV3, [0] PLV0)
//  dmw1        in   32  DMW1 CSR value, same layout
//  crmd_plv    in   2   current privilege level
//  crmd_da     in   1   direct-address mode
//  crmd_pg     in   1   paged mode
//  crmd_datm   in   2   MAT used in DA mode
//  req_valid   in   1   request valid
//  req_ready   out  1   request accepted when req_valid & req_ready
//  req_vaddr   in   32  virtual address
//  resp_valid  out  1   response valid
//  resp_ready  in   1   response consumed when resp_valid & resp_ready
//  resp_paddr  out  32  physical address (vaddr when miss)
//  resp_mat    out  2   memory access type (0 when miss)
//  resp_hit    out  2   one-hot {dmw1,dmw0} hit; 0 for DA or miss
//  resp_miss   out  1   PG mode, no window hit -> TLB lookup required
//  resp_adem   out  1   address error (see CONFIGURATION)
//  hit_cnt     out  HIT_CNT_W  saturating count of accepted DMW hits
// BEHAVIOUR
//  - Reset: every stage valid=0, resp_* payload=0, hit_cnt=0, req_ready=1 in the cycle after reset deasserts.
//  - S1 captures vaddr and the compare result on accept. DMW and CRMD are sampled in the accept cycle;
//    later CSR writes do not affect in-flight entries.
//  - S2 holds the registered response. Latency is exactly 2 cycles: accept at N -> resp_valid at N+2 if unstalled.
//  - s2_adv = !s2_valid | resp_ready; s1_adv = s2_adv; req_ready = !s1_valid | s1_adv (combinational).
//  - Full throughput: 1 req/cycle with resp_ready=1. A stall holds S1 and S2 and keeps the payload stable.
//  - resp_valid is never dropped without a handshake, except on flush/rst.
//  - Window match for DMWi: vaddr[31:29]==dmwi[31:29] && ((plv==0 && dmwi[0]) || (plv==3 && dmwi[3])).
//    PLV 1/2 never match.
//  - Both windows match -> DMW0 wins; resp_hit=2'b01.
//  - DA=1 (PG ignored): paddr=vaddr, mat=datm, hit=0, miss=0.
//  - DA=0, PG=1, hit on DMWi: paddr={dmwi[27:25],vaddr[28:0]}, mat=dmwi[5:4], miss=0.
//  - DA=0, PG=1, no hit: paddr=vaddr, mat=0, miss=1.
//  - DA=0, PG=0 (illegal CRMD): treated as DA with mat=datm.
//  - hit_cnt increments at the S2 handshake when resp_hit!=0. It saturates at all-ones and does not wrap.
//  - flush: S1/S2 valid cleared next cycle. A request offered in the flush cycle is not accepted
//    (req_ready=0 while flush=1). hit_cnt is untouched.
//  - rst has priority over flush and clears hit_cnt.
// CONFIGURATION
//  DMW_ADEM_EN defined:
//    resp_adem=1 when DA=0, PG=1, plv==3, vaddr[31]==1 and no window hit.
//    In that case resp_miss is forced to 0 and the paddr/mat outputs are as for a miss.
//  DMW_ADEM_EN undefined: resp_adem tied 0; no extra logic.
// TESTING
//  1 dmw0=0xA0000011, PG, plv0, vaddr 0xA0001234 -> N+2: paddr 0x00001234, mat 1, hit 01, hit_cnt 1.
//  2 dmw0 and dmw1=0x80000029 both VSEG=4, plv3, vaddr 0x9000_0040 -> only dmw1 PLV3 set: paddr 0x00000040? no:
//    PSEG=0 -> paddr 0x10000040, mat 2, hit 10.
//    Repeat with dmw0=0x80000009 -> hit 01 (priority).
//  3 DA=1, datm=1, vaddr 0x1234_5678 -> paddr 0x12345678, mat 1, hit 0, miss 0, hit_cnt unchanged.
//  4 PG, plv3, vaddr 0xC000_0000, no window -> miss=1; with DMW_ADEM_EN: adem=1, miss=0.
//  5 Back-to-back 4 reqs, resp_ready low 3 cycles mid-stream -> req_ready drops with S1+S2 full,
//    payload stable, all 4 in order, none lost.
//  6 flush with S1,S2 full and req_valid=1 -> next cycle resp_valid=0, req not taken.
//    Also preload hit_cnt near max -> saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/dmw_addr_translate.sv
// -----------------------------------------------------------------------------
// dmw_addr_translate
//
// Translates a 32-bit virtual address to a physical address using the
// direct-mapped windows DMW0/DMW1 and the CRMD mode bits. The block sits
// between address generation and the cache tag stage. It is a two-stage
// valid/ready pipeline:
//   S1 - captures the translation result computed in the accept cycle. CSRs
//        are sampled only then, so later CSR writes never disturb in-flight
//        entries.
//   S2 - holds the registered response presented on resp_*.
// An accept in cycle N gives resp_valid in cycle N+2 when nothing stalls.
//
// Outcomes:
//   direct (CRMD.DA, or illegal DA=0/PG=0)  paddr=vaddr, mat=datm
//   window hit (DMW0 has priority)          paddr={PSEG,vaddr[28:0]}, mat=MAT
//   miss (paged, no window)                 paddr=vaddr, mat=0, miss=1
//
// Optional feature (macro DMW_ADEM_EN): a user-mode (PLV3) access to the
// upper half of the address space that hits no window reports resp_adem=1
// instead of resp_miss. When the macro is undefined, resp_adem is tied to 0.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   flush                  kills S1 and S2; blocks acceptance this cycle
//   dmw0, dmw1             DMW CSR values
//   crmd_plv/da/pg/datm    current mode fields
//   req_valid/ready/vaddr  request handshake and virtual address
//   resp_valid/ready       response handshake
//   resp_paddr/mat/hit     translation result
//   resp_miss, resp_adem   TLB-required / address-error flags
//   hit_cnt                saturating count of consumed window hits
// -----------------------------------------------------------------------------
module dmw_addr_translate #(
    parameter int HIT_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [31:0]          dmw0,
    input  logic [31:0]          dmw1,
    input  logic [1:0]           crmd_plv,
    input  logic                 crmd_da,
    input  logic                 crmd_pg,
    input  logic [1:0]           crmd_datm,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_vaddr,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_paddr,
    output logic [1:0]           resp_mat,
    output logic [1:0]           resp_hit,
    output logic                 resp_miss,
    output logic                 resp_adem,
    output logic [HIT_CNT_W-1:0] hit_cnt
);

    localparam logic [1:0] PLV_KERNEL = 2'd0;
    localparam logic [1:0] PLV_USER   = 2'd3;
    localparam logic [HIT_CNT_W-1:0] CNT_MAX = {HIT_CNT_W{1'b1}};
    localparam logic [HIT_CNT_W-1:0] CNT_ONE = {{(HIT_CNT_W-1){1'b0}}, 1'b1};

    // Window match: VSEG compare plus the privilege-enable bit for the current
    // level. PLV1/PLV2 have no enable bit and therefore never match.
    function automatic logic win_match(input logic [31:0] dmw,
                                       input logic [31:0] vaddr,
                                       input logic [1:0]  plv);
        logic plv_ok;
        plv_ok = ((plv == PLV_KERNEL) && dmw[0]) || ((plv == PLV_USER) && dmw[3]);
        return (vaddr[31:29] == dmw[31:29]) && plv_ok;
    endfunction

    // Translation result for the address currently offered
    logic        win0_s;
    logic        win1_s;
    logic [31:0] xl_paddr_s;
    logic [1:0]  xl_mat_s;
    logic [1:0]  xl_hit_s;
    logic        xl_miss_s;

    // Handshake
    logic s2_adv_s;
    logic s1_adv_s;
    logic s1_load_s;
    logic accept_s;

    // Pipeline registers
    logic        s1_valid_r;
    logic [31:0] s1_paddr_r;
    logic [1:0]  s1_mat_r;
    logic [1:0]  s1_hit_r;
    logic        s1_miss_r;
    logic        s2_valid_r;
    logic [31:0] s2_paddr_r;
    logic [1:0]  s2_mat_r;
    logic [1:0]  s2_hit_r;
    logic        s2_miss_r;
    logic [HIT_CNT_W-1:0] hit_cnt_r;

`ifdef DMW_ADEM_EN
    logic xl_adem_s;
    logic s1_adem_r;
    logic s2_adem_r;
`endif

    // Only VSEG, PSEG, MAT and the PLV enables are meaningful in the DMW CSRs
    logic unused_dmw_bits_s;
    assign unused_dmw_bits_s = ^{dmw0[28], dmw0[24:6], dmw0[2:1],
                                 dmw1[28], dmw1[24:6], dmw1[2:1]};

    assign win0_s = win_match(dmw0, req_vaddr, crmd_plv);
    assign win1_s = win_match(dmw1, req_vaddr, crmd_plv);

    // Translation of the offered address; DA=0/PG=0 falls back to direct mode
    always_comb begin
        xl_paddr_s = req_vaddr;
        xl_mat_s   = 2'b00;
        xl_hit_s   = 2'b00;
        xl_miss_s  = 1'b0;
`ifdef DMW_ADEM_EN
        xl_adem_s  = 1'b0;
`endif
        if (crmd_da || !crmd_pg) begin
            xl_mat_s = crmd_datm;
        end else if (win0_s) begin
            xl_paddr_s = {dmw0[27:25], req_vaddr[28:0]};
            xl_mat_s   = dmw0[5:4];
            xl_hit_s   = 2'b01;
        end else if (win1_s) begin
            xl_paddr_s = {dmw1[27:25], req_vaddr[28:0]};
            xl_mat_s   = dmw1[5:4];
            xl_hit_s   = 2'b10;
        end else begin
`ifdef DMW_ADEM_EN
            // User access to the kernel half with no window is an address error
            if ((crmd_plv == PLV_USER) && req_vaddr[31]) begin
                xl_adem_s = 1'b1;
                xl_miss_s = 1'b0;
            end else begin
                xl_adem_s = 1'b0;
                xl_miss_s = 1'b1;
            end
`else
            xl_miss_s = 1'b1;
`endif
        end
    end

    // Backpressure chain: S1 can move when S2 can move; S1 may also load while
    // empty even if S2 is stalled. Nothing is accepted in a flush cycle.
    always_comb begin
        s2_adv_s  = !s2_valid_r || resp_ready;
        s1_adv_s  = s2_adv_s;
        s1_load_s = !s1_valid_r || s1_adv_s;
        req_ready = s1_load_s && !flush;
        accept_s  = req_valid && req_ready;
    end

    // Pipeline stages and hit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_paddr_r <= 32'h0000_0000;
            s1_mat_r   <= 2'b00;
            s1_hit_r   <= 2'b00;
            s1_miss_r  <= 1'b0;
            s2_valid_r <= 1'b0;
            s2_paddr_r <= 32'h0000_0000;
            s2_mat_r   <= 2'b00;
            s2_hit_r   <= 2'b00;
            s2_miss_r  <= 1'b0;
            hit_cnt_r  <= {HIT_CNT_W{1'b0}};
`ifdef DMW_ADEM_EN
            s1_adem_r  <= 1'b0;
            s2_adem_r  <= 1'b0;
`endif
        end else if (flush) begin
            // Payload is left as-is; only the valids are killed
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (s1_load_s) begin
                s1_valid_r <= accept_s;
                if (accept_s) begin
                    s1_paddr_r <= xl_paddr_s;
                    s1_mat_r   <= xl_mat_s;
                    s1_hit_r   <= xl_hit_s;
                    s1_miss_r  <= xl_miss_s;
`ifdef DMW_ADEM_EN
                    s1_adem_r  <= xl_adem_s;
`endif
                end
            end
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    s2_paddr_r <= s1_paddr_r;
                    s2_mat_r   <= s1_mat_r;
                    s2_hit_r   <= s1_hit_r;
                    s2_miss_r  <= s1_miss_r;
`ifdef DMW_ADEM_EN
                    s2_adem_r  <= s1_adem_r;
`endif
                end
            end
            // Count window hits as they are consumed; hold at all-ones
            if (s2_valid_r && resp_ready && (s2_hit_r != 2'b00) && (hit_cnt_r != CNT_MAX)) begin
                hit_cnt_r <= hit_cnt_r + CNT_ONE;
            end
        end
    end

    assign resp_valid = s2_valid_r;
    assign resp_paddr = s2_paddr_r;
    assign resp_mat   = s2_mat_r;
    assign resp_hit   = s2_hit_r;
    assign resp_miss  = s2_miss_r;
    assign hit_cnt    = hit_cnt_r;
`ifdef DMW_ADEM_EN
    assign resp_adem  = s2_adem_r;
`else
    assign resp_adem  = 1'b0;
`endif

endmodule

// File: tb/tb_dmw_addr_translate.sv
// Directed testbench for dmw_addr_translate. Uses a narrow hit counter so that
// saturation can be reached in a short run.
module tb_dmw_addr_translate;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};
`ifdef DMW_ADEM_EN
    localparam logic ADEM = 1'b1;
`else
    localparam logic ADEM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [31:0]   dmw0, dmw1;
    logic [1:0]    crmd_plv;
    logic          crmd_da, crmd_pg;
    logic [1:0]    crmd_datm;
    logic          req_valid, req_ready;
    logic [31:0]   req_vaddr;
    logic          resp_valid, resp_ready;
    logic [31:0]   resp_paddr;
    logic [1:0]    resp_mat, resp_hit;
    logic          resp_miss, resp_adem;
    logic [CW-1:0] hit_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [CW-1:0] exp_cnt;

    always #5 clk = ~clk;

    dmw_addr_translate #(.HIT_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dmw0(dmw0), .dmw1(dmw1),
        .crmd_plv(crmd_plv), .crmd_da(crmd_da), .crmd_pg(crmd_pg), .crmd_datm(crmd_datm),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_paddr(resp_paddr), .resp_mat(resp_mat), .resp_hit(resp_hit),
        .resp_miss(resp_miss), .resp_adem(resp_adem), .hit_cnt(hit_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic [1:0] hit);
        if (hit != 2'b00 && c != CMAX) return c + 1'b1;
        return c;
    endfunction

    // One isolated transaction with resp_ready=1: checks latency, payload and
    // the counter after the consuming handshake. corrupt scrambles CSRs after
    // the accept edge to show they were sampled at accept.
    task automatic single(input string tag, input logic [31:0] v,
                          input logic [31:0] ep, input logic [1:0] em, input logic [1:0] eh,
                          input logic emiss, input logic eadem, input logic corrupt);
        @(negedge clk);
        req_valid = 1'b1;
        req_vaddr = v;
        #1 check_val({tag, ".rdy"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (corrupt) begin
            dmw0 = 32'h0; dmw1 = 32'h0; crmd_plv = 2'd1;
        end
        check_val({tag, ".lat"}, {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check_val({tag, ".vld"},  {31'd0, resp_valid}, 32'd1);
        check_val({tag, ".pa"},   resp_paddr, ep);
        check_val({tag, ".mat"},  {30'd0, resp_mat}, {30'd0, em});
        check_val({tag, ".hit"},  {30'd0, resp_hit}, {30'd0, eh});
        check_val({tag, ".miss"}, {31'd0, resp_miss}, {31'd0, emiss});
        check_val({tag, ".adem"}, {31'd0, resp_adem}, {31'd0, eadem});
        @(posedge clk); #1;
        exp_cnt = sat_inc(exp_cnt, eh);
        check_val({tag, ".cnt"},  {28'd0, hit_cnt}, {28'd0, exp_cnt});
        check_val({tag, ".done"}, {31'd0, resp_valid}, 32'd0);
    endtask

    logic [31:0] vec  [4];
    logic [31:0] vpa  [4];
    logic [1:0]  vmat [4];
    logic [1:0]  vhit [4];

    initial begin : main
        int i, j;
        logic stall_seen, prev_stall, acc;
        logic [31:0] prev_paddr;

        rst = 1'b1; flush = 1'b0;
        dmw0 = 32'hA000_0011; dmw1 = 32'h0;
        crmd_plv = 2'd0; crmd_da = 1'b0; crmd_pg = 1'b1; crmd_datm = 2'd0;
        req_valid = 1'b0; req_vaddr = 32'h0; resp_ready = 1'b1;
        exp_cnt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        check_val("rst.rdy",  {31'd0, req_ready}, 32'd1);
        check_val("rst.vld",  {31'd0, resp_valid}, 32'd0);
        check_val("rst.pa",   resp_paddr, 32'd0);
        check_val("rst.flags", {26'd0, resp_mat, resp_hit, resp_miss, resp_adem}, 32'd0);
        check_val("rst.cnt",  {28'd0, hit_cnt}, 32'd0);

        // 1: DMW0 hit at PLV0, CSRs clobbered after accept
        single("t1", 32'hA000_1234, 32'h0000_1234, 2'd1, 2'b01, 1'b0, 1'b0, 1'b1);

        // 2: both VSEG=4, PLV3; DMW0 lacks PLV3 so DMW1 hits
        dmw0 = 32'h8000_0011; dmw1 = 32'h8000_0029; crmd_plv = 2'd3;
        single("t2a", 32'h9000_0040, 32'h1000_0040, 2'd2, 2'b10, 1'b0, 1'b0, 1'b0);
        // both windows enabled -> DMW0 wins
        dmw0 = 32'h8000_0009; dmw1 = 32'h8000_0029; crmd_plv = 2'd3;
        single("t2b", 32'h9000_0040, 32'h1000_0040, 2'd0, 2'b01, 1'b0, 1'b0, 1'b0);
        // PLV1 never matches -> plain miss
        crmd_plv = 2'd1;
        single("t2c", 32'h9000_0040, 32'h9000_0040, 2'd0, 2'b00, 1'b1, 1'b0, 1'b0);

        // 3: DA mode, then illegal DA=0/PG=0 treated as DA
        crmd_plv = 2'd0; crmd_da = 1'b1; crmd_datm = 2'd1;
        single("t3a", 32'h1234_5678, 32'h1234_5678, 2'd1, 2'b00, 1'b0, 1'b0, 1'b0);
        crmd_da = 1'b0; crmd_pg = 1'b0; crmd_datm = 2'd3; dmw0 = 32'hA000_0011;
        single("t3b", 32'hA000_1234, 32'hA000_1234, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0);

        // 4: PG, PLV3, no window; upper half vs lower half
        crmd_pg = 1'b1; crmd_plv = 2'd3; dmw0 = 32'hA000_0011; dmw1 = 32'h8000_0029;
        single("t4a", 32'hC000_0000, 32'hC000_0000, 2'd0, 2'b00, !ADEM, ADEM, 1'b0);
        single("t4b", 32'h4000_0000, 32'h4000_0000, 2'd0, 2'b00, 1'b1, 1'b0, 1'b0);

        // 5: back-to-back stream with a 3-cycle consumer stall
        crmd_plv = 2'd0; dmw0 = 32'hA600_0011; dmw1 = 32'h8C00_0021;
        vec[0] = 32'hA000_0100; vpa[0] = 32'h6000_0100; vmat[0] = 2'd1; vhit[0] = 2'b01;
        vec[1] = 32'h0000_0200; vpa[1] = 32'h0000_0200; vmat[1] = 2'd0; vhit[1] = 2'b00;
        vec[2] = 32'hA000_0300; vpa[2] = 32'h6000_0300; vmat[2] = 2'd1; vhit[2] = 2'b01;
        vec[3] = 32'h8000_0400; vpa[3] = 32'hC000_0400; vmat[3] = 2'd2; vhit[3] = 2'b10;
        i = 0; j = 0; stall_seen = 1'b0; prev_stall = 1'b0; prev_paddr = 32'h0;
        for (int cyc = 0; cyc < 40 && j < 4; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                check_val("t5.hold_v",  {31'd0, resp_valid}, 32'd1);
                check_val("t5.hold_pa", resp_paddr, prev_paddr);
            end
            resp_ready = (cyc >= 2 && cyc <= 4) ? 1'b0 : 1'b1;
            req_valid  = (i < 4);
            if (i < 4) req_vaddr = vec[i];
            #1;
            if (!resp_ready && !req_ready) stall_seen = 1'b1;
            if (resp_valid && resp_ready) begin
                check_val("t5.pa",  resp_paddr, vpa[j]);
                check_val("t5.mat", {30'd0, resp_mat}, {30'd0, vmat[j]});
                check_val("t5.hit", {30'd0, resp_hit}, {30'd0, vhit[j]});
                exp_cnt = sat_inc(exp_cnt, vhit[j]);
                j++;
            end
            prev_stall = resp_valid && !resp_ready;
            prev_paddr = resp_paddr;
            acc = req_valid && req_ready;
            @(posedge clk);
            if (acc) i++;
        end
        req_valid = 1'b0;
        #1;
        check_val("t5.count", j, 32'd4);
        check_val("t5.stall", {31'd0, stall_seen}, 32'd1);
        check_val("t5.cnt", {28'd0, hit_cnt}, {28'd0, exp_cnt});

        // 6: flush with S1 and S2 full and a request offered
        resp_ready = 1'b0;
        @(negedge clk); req_valid = 1'b1; req_vaddr = 32'hA000_0010;
        @(posedge clk);
        @(negedge clk); req_vaddr = 32'hA000_0020;
        @(posedge clk);
        @(negedge clk); flush = 1'b1; req_vaddr = 32'hA000_0030;
        #1;
        check_val("t6.rdy",  {31'd0, req_ready}, 32'd0);
        check_val("t6.full", {31'd0, resp_valid}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        check_val("t6.kill", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check_val("t6.s1kill", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check_val("t6.notaken", {31'd0, resp_valid}, 32'd0);
        check_val("t6.cnt", {28'd0, hit_cnt}, {28'd0, exp_cnt});

        // Saturation of the hit counter
        for (int k = 0; k < 12; k++)
            single("sat", 32'hA000_0000, 32'h6000_0000, 2'd1, 2'b01, 1'b0, 1'b0, 1'b0);
        check_val("sat.max", {28'd0, hit_cnt}, {28'd0, CMAX});

        // Reset clears the counter
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        check_val("rst2.cnt", {28'd0, hit_cnt}, 32'd0);
        check_val("rst2.vld", {31'd0, resp_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
